axi_mmu_win: RTL and testbench

Parametrised AXI3 (64-bit data, 4-bit len) address-window MMU between the application CPU master port and the system interconnect. It matches every AW/AR address against P_NWIN windows and remaps permitted accesses to a target base. Accesses that match no window, or lack the required permission, are terminated locally with DECERR and never reach the interconnect. Outstanding forwarded transactions are drained before a local error response is issued, so response ordering per ID is preserved.

---
 rtl/axi_mmu_win.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi_mmu_win.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mmu_win.sv
// axi_mmu_win: AXI3 address-window MMU.
// Matches every AW/AR address against P_NWIN windows (lowest index wins) and
// remaps permitted accesses onto the window's target base. Unmapped or
// permission-denied accesses are terminated locally with DECERR after all
// forwarded transactions of that direction have drained, which keeps
// per-ID response ordering intact.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   axis_*          - slave AXI3 port from the CPU (AW, W+wid, B, AR, R)
//   axim_*          - master AXI3 port to the interconnect (same signal set)
module axi_mmu_win #(
  parameter int                    P_AXI_IDWIDTH = 4,
  parameter int                    P_NWIN        = 4,
  parameter logic [32*P_NWIN-1:0]  P_WIN_BASE    = {P_NWIN{32'h0}},
  parameter logic [32*P_NWIN-1:0]  P_WIN_MASK    = {P_NWIN{32'hFE00_0000}},
  parameter logic [32*P_NWIN-1:0]  P_WIN_TARGET  = {P_NWIN{32'h0200_0000}},
  parameter logic [2*P_NWIN-1:0]   P_WIN_PERM    = {P_NWIN{2'b11}},
  parameter int                    P_MAX_OUTST   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // slave AW / W / B
  input  logic [P_AXI_IDWIDTH-1:0] axis_awid,
  input  logic [31:0]              axis_awaddr,
  input  logic [3:0]               axis_awlen,
  input  logic [2:0]               axis_awsize,
  input  logic [1:0]               axis_awburst,
  input  logic                     axis_awvalid,
  output logic                     axis_awready,
  input  logic [P_AXI_IDWIDTH-1:0] axis_wid,
  input  logic [63:0]              axis_wdata,
  input  logic [7:0]               axis_wstrb,
  input  logic                     axis_wlast,
  input  logic                     axis_wvalid,
  output logic                     axis_wready,
  output logic [P_AXI_IDWIDTH-1:0] axis_bid,
  output logic [1:0]               axis_bresp,
  output logic                     axis_bvalid,
  input  logic                     axis_bready,
  // slave AR / R
  input  logic [P_AXI_IDWIDTH-1:0] axis_arid,
  input  logic [31:0]              axis_araddr,
  input  logic [3:0]               axis_arlen,
  input  logic [2:0]               axis_arsize,
  input  logic [1:0]               axis_arburst,
  input  logic                     axis_arvalid,
  output logic                     axis_arready,
  output logic [P_AXI_IDWIDTH-1:0] axis_rid,
  output logic [63:0]              axis_rdata,
  output logic [1:0]               axis_rresp,
  output logic                     axis_rlast,
  output logic                     axis_rvalid,
  input  logic                     axis_rready,
  // master AW / W / B
  output logic [P_AXI_IDWIDTH-1:0] axim_awid,
  output logic [31:0]              axim_awaddr,
  output logic [3:0]               axim_awlen,
  output logic [2:0]               axim_awsize,
  output logic [1:0]               axim_awburst,
  output logic                     axim_awvalid,
  input  logic                     axim_awready,
  output logic [P_AXI_IDWIDTH-1:0] axim_wid,
  output logic [63:0]              axim_wdata,
  output logic [7:0]               axim_wstrb,
  output logic                     axim_wlast,
  output logic                     axim_wvalid,
  input  logic                     axim_wready,
  input  logic [P_AXI_IDWIDTH-1:0] axim_bid,
  input  logic [1:0]               axim_bresp,
  input  logic                     axim_bvalid,
  output logic                     axim_bready,
  // master AR / R
  output logic [P_AXI_IDWIDTH-1:0] axim_arid,
  output logic [31:0]              axim_araddr,
  output logic [3:0]               axim_arlen,
  output logic [2:0]               axim_arsize,
  output logic [1:0]               axim_arburst,
  output logic                     axim_arvalid,
  input  logic                     axim_arready,
  input  logic [P_AXI_IDWIDTH-1:0] axim_rid,
  input  logic [63:0]              axim_rdata,
  input  logic [1:0]               axim_rresp,
  input  logic                     axim_rlast,
  input  logic                     axim_rvalid,
  output logic                     axim_rready
);

  localparam logic [3:0] MAX_OUT = 4'(P_MAX_OUTST);

  typedef struct packed {
    logic        hit;
    logic [1:0]  perm;
    logic [31:0] addr;
  } lu_t;

  // Walk from the top index down so the lowest-index hit overwrites the rest.
  function automatic lu_t lookup(input logic [31:0] a);
    lu_t r;
    r = '0;
    for (int i = P_NWIN - 1; i >= 0; i--) begin
      if ((a & P_WIN_MASK[32*i +: 32]) == (P_WIN_BASE[32*i +: 32] & P_WIN_MASK[32*i +: 32])) begin
        r.hit  = 1'b1;
        r.perm = P_WIN_PERM[2*i +: 2];
        r.addr = (P_WIN_TARGET[32*i +: 32] & P_WIN_MASK[32*i +: 32]) |
                 (a & ~P_WIN_MASK[32*i +: 32]);
      end
    end
    return r;
  endfunction

  lu_t  aw_lu, ar_lu;
  logic aw_ok, ar_ok;

  always_comb begin
    aw_lu = lookup(axis_awaddr);
    ar_lu = lookup(axis_araddr);
    aw_ok = aw_lu.hit & aw_lu.perm[1];
    ar_ok = ar_lu.hit & ar_lu.perm[0];
  end

  // Address/data payloads always pass; only the valid/ready pairs are gated.
  assign axim_awid    = axis_awid;
  assign axim_awaddr  = aw_lu.addr;
  assign axim_awlen   = axis_awlen;
  assign axim_awsize  = axis_awsize;
  assign axim_awburst = axis_awburst;
  assign axim_wid     = axis_wid;
  assign axim_wdata   = axis_wdata;
  assign axim_wstrb   = axis_wstrb;
  assign axim_wlast   = axis_wlast;
  assign axim_arid    = axis_arid;
  assign axim_araddr  = ar_lu.addr;
  assign axim_arlen   = axis_arlen;
  assign axim_arsize  = axis_arsize;
  assign axim_arburst = axis_arburst;

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_SINK, W_ERESP} wst_t;
  wst_t                     w_st, w_nxt;
  logic [3:0]               wr_outst;
  logic [P_AXI_IDWIDTH-1:0] bid_q;

  always_comb begin
    w_nxt        = w_st;
    axim_awvalid = 1'b0;
    axis_awready = 1'b0;
    axim_wvalid  = 1'b0;
    axis_wready  = 1'b0;
    axis_bvalid  = axim_bvalid;
    axis_bid     = axim_bid;
    axis_bresp   = axim_bresp;
    axim_bready  = axis_bready;
    case (w_st)
      W_IDLE: begin
        if (aw_ok) begin
          if (wr_outst < MAX_OUT) begin
            axim_awvalid = axis_awvalid;
            axis_awready = axim_awready;
            if (axis_awvalid && axim_awready) w_nxt = W_FWD;
          end
        end else if (wr_outst == 4'd0) begin
          // blocked: only once every forwarded write has its B back
          axis_awready = 1'b1;
          if (axis_awvalid) w_nxt = W_SINK;
        end
      end
      W_FWD: begin
        axim_wvalid = axis_wvalid;
        axis_wready = axim_wready;
        if (axis_wvalid && axim_wready && axis_wlast) w_nxt = W_IDLE;
      end
      W_SINK: begin
        axis_wready = 1'b1;
        if (axis_wvalid && axis_wlast) w_nxt = W_ERESP;
      end
      W_ERESP: begin
        axis_bvalid = 1'b1;
        axis_bresp  = 2'b11;
        axis_bid    = bid_q;
        axim_bready = 1'b0;
        if (axis_bready) w_nxt = W_IDLE;
      end
      default: w_nxt = W_IDLE;
    endcase
    if (!rst_n) begin
      axim_awvalid = 1'b0;
      axis_awready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_st     <= W_IDLE;
      wr_outst <= 4'd0;
      bid_q    <= '0;
    end else begin
      w_st <= w_nxt;
      if (w_st == W_IDLE && w_nxt == W_SINK) bid_q <= axis_awid;
      case ({axim_awvalid && axim_awready, axim_bvalid && axim_bready})
        2'b10:   wr_outst <= wr_outst + 4'd1;
        2'b01:   wr_outst <= wr_outst - 4'd1;
        default: wr_outst <= wr_outst;
      endcase
    end
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_ERR} rst_t;
  rst_t                     r_st, r_nxt;
  logic [3:0]               rd_outst;
  logic [P_AXI_IDWIDTH-1:0] rid_q;
  logic [3:0]               rlen_q, beat;

  always_comb begin
    r_nxt        = r_st;
    axim_arvalid = 1'b0;
    axis_arready = 1'b0;
    axis_rvalid  = axim_rvalid;
    axis_rid     = axim_rid;
    axis_rdata   = axim_rdata;
    axis_rresp   = axim_rresp;
    axis_rlast   = axim_rlast;
    axim_rready  = axis_rready;
    case (r_st)
      R_IDLE: begin
        if (ar_ok) begin
          if (rd_outst < MAX_OUT) begin
            axim_arvalid = axis_arvalid;
            axis_arready = axim_arready;
          end
        end else if (rd_outst == 4'd0) begin
          axis_arready = 1'b1;
          if (axis_arvalid) r_nxt = R_ERR;
        end
      end
      R_ERR: begin
        axis_rvalid = 1'b1;
        axis_rid    = rid_q;
        axis_rdata  = '0;
        axis_rresp  = 2'b11;
        axis_rlast  = (beat == rlen_q);
        axim_rready = 1'b0;
        if (axis_rready && beat == rlen_q) r_nxt = R_IDLE;
      end
      default: r_nxt = R_IDLE;
    endcase
    if (!rst_n) begin
      axim_arvalid = 1'b0;
      axis_arready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= R_IDLE;
      rd_outst <= 4'd0;
      rid_q    <= '0;
      rlen_q   <= 4'd0;
      beat     <= 4'd0;
    end else begin
      r_st <= r_nxt;
      if (r_st == R_IDLE && r_nxt == R_ERR) begin
        rid_q  <= axis_arid;
        rlen_q <= axis_arlen;
        beat   <= 4'd0;
      end else if (r_st == R_ERR && axis_rready) begin
        beat <= beat + 4'd1;
      end
      case ({axim_arvalid && axim_arready, axim_rvalid && axim_rready && axim_rlast})
        2'b10:   rd_outst <= rd_outst + 4'd1;
        2'b01:   rd_outst <= rd_outst - 4'd1;
        default: rd_outst <= rd_outst;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mmu_win.sv
// Directed bench for axi_mmu_win: a vector table for address match/remap and
// permission decisions, plus hand-written multi-cycle sequences for the
// forwarded/blocked write and read paths, drain stalls, outstanding limit
// and reset during an error burst.
module tb_axi_mmu_win;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IDW-1:0] axis_awid, axis_wid, axis_bid, axis_arid, axis_rid;
  logic [31:0]    axis_awaddr, axis_araddr;
  logic [3:0]     axis_awlen, axis_arlen;
  logic [2:0]     axis_awsize, axis_arsize;
  logic [1:0]     axis_awburst, axis_arburst, axis_bresp, axis_rresp;
  logic           axis_awvalid, axis_awready, axis_wlast, axis_wvalid, axis_wready;
  logic           axis_bvalid, axis_bready, axis_arvalid, axis_arready;
  logic           axis_rlast, axis_rvalid, axis_rready;
  logic [63:0]    axis_wdata, axis_rdata;
  logic [7:0]     axis_wstrb;

  logic [IDW-1:0] axim_awid, axim_wid, axim_bid, axim_arid, axim_rid;
  logic [31:0]    axim_awaddr, axim_araddr;
  logic [3:0]     axim_awlen, axim_arlen;
  logic [2:0]     axim_awsize, axim_arsize;
  logic [1:0]     axim_awburst, axim_arburst, axim_bresp, axim_rresp;
  logic           axim_awvalid, axim_awready, axim_wlast, axim_wvalid, axim_wready;
  logic           axim_bvalid, axim_bready, axim_arvalid, axim_arready;
  logic           axim_rlast, axim_rvalid, axim_rready;
  logic [63:0]    axim_wdata, axim_rdata;
  logic [7:0]     axim_wstrb;

  // W0: 0x0000_0000/7 bits -> 0x0200_0000, RW
  // W1: 0x8xxx_xxxx         -> 0x1xxx_xxxx, read only
  // W2: bit31 set           -> bit31 cleared, write only (shadowed by W1 for 0x8...)
  axi_mmu_win #(
    .P_AXI_IDWIDTH(IDW),
    .P_NWIN(3),
    .P_WIN_BASE  ({32'h8000_0000, 32'h8000_0000, 32'h0000_0000}),
    .P_WIN_MASK  ({32'h8000_0000, 32'hF000_0000, 32'hFE00_0000}),
    .P_WIN_TARGET({32'h0000_0000, 32'h1000_0000, 32'h0200_0000}),
    .P_WIN_PERM  ({2'b10, 2'b01, 2'b11}),
    .P_MAX_OUTST(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_awid(axis_awid), .axis_awaddr(axis_awaddr), .axis_awlen(axis_awlen),
    .axis_awsize(axis_awsize), .axis_awburst(axis_awburst), .axis_awvalid(axis_awvalid),
    .axis_awready(axis_awready),
    .axis_wid(axis_wid), .axis_wdata(axis_wdata), .axis_wstrb(axis_wstrb),
    .axis_wlast(axis_wlast), .axis_wvalid(axis_wvalid), .axis_wready(axis_wready),
    .axis_bid(axis_bid), .axis_bresp(axis_bresp), .axis_bvalid(axis_bvalid),
    .axis_bready(axis_bready),
    .axis_arid(axis_arid), .axis_araddr(axis_araddr), .axis_arlen(axis_arlen),
    .axis_arsize(axis_arsize), .axis_arburst(axis_arburst), .axis_arvalid(axis_arvalid),
    .axis_arready(axis_arready),
    .axis_rid(axis_rid), .axis_rdata(axis_rdata), .axis_rresp(axis_rresp),
    .axis_rlast(axis_rlast), .axis_rvalid(axis_rvalid), .axis_rready(axis_rready),
    .axim_awid(axim_awid), .axim_awaddr(axim_awaddr), .axim_awlen(axim_awlen),
    .axim_awsize(axim_awsize), .axim_awburst(axim_awburst), .axim_awvalid(axim_awvalid),
    .axim_awready(axim_awready),
    .axim_wid(axim_wid), .axim_wdata(axim_wdata), .axim_wstrb(axim_wstrb),
    .axim_wlast(axim_wlast), .axim_wvalid(axim_wvalid), .axim_wready(axim_wready),
    .axim_bid(axim_bid), .axim_bresp(axim_bresp), .axim_bvalid(axim_bvalid),
    .axim_bready(axim_bready),
    .axim_arid(axim_arid), .axim_araddr(axim_araddr), .axim_arlen(axim_arlen),
    .axim_arsize(axim_arsize), .axim_arburst(axim_arburst), .axim_arvalid(axim_arvalid),
    .axim_arready(axim_arready),
    .axim_rid(axim_rid), .axim_rdata(axim_rdata), .axim_rresp(axim_rresp),
    .axim_rlast(axim_rlast), .axim_rvalid(axim_rvalid), .axim_rready(axim_rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic        fwd;
    logic [31:0] oaddr;
  } vec_t;
  vec_t vt[11];

  initial begin
    int beats;
    vt[0]  = '{1'b1, 32'h0012_3400, 1'b1, 32'h0212_3400};
    vt[1]  = '{1'b0, 32'h0012_3400, 1'b1, 32'h0212_3400};
    vt[2]  = '{1'b1, 32'h8000_0010, 1'b0, 32'h0};         // W1 hit, no write perm
    vt[3]  = '{1'b0, 32'h8000_0010, 1'b1, 32'h1000_0010};  // W1 wins over W2
    vt[4]  = '{1'b0, 32'h4000_0000, 1'b0, 32'h0};          // unmapped
    vt[5]  = '{1'b1, 32'hA000_1234, 1'b1, 32'h2000_1234};  // W2 write
    vt[6]  = '{1'b0, 32'hA000_1234, 1'b0, 32'h0};          // W2 no read perm
    vt[7]  = '{1'b1, 32'h01FF_FFFC, 1'b1, 32'h03FF_FFFC};  // top of W0
    vt[8]  = '{1'b1, 32'h0200_0000, 1'b0, 32'h0};          // just above W0
    vt[9]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[10] = '{1'b1, 32'hFFFF_FFF0, 1'b1, 32'h7FFF_FFF0};

    axis_awid = '0; axis_awaddr = '0; axis_awlen = '0; axis_awsize = 3'd3; axis_awburst = 2'b01;
    axis_awvalid = 0; axis_wid = '0; axis_wdata = '0; axis_wstrb = 8'hFF; axis_wlast = 0;
    axis_wvalid = 0; axis_bready = 0; axis_arid = '0; axis_araddr = '0; axis_arlen = '0;
    axis_arsize = 3'd3; axis_arburst = 2'b01; axis_arvalid = 0; axis_rready = 0;
    axim_awready = 0; axim_wready = 0; axim_bid = '0; axim_bresp = '0; axim_bvalid = 0;
    axim_arready = 0; axim_rid = '0; axim_rdata = '0; axim_rresp = '0; axim_rlast = 0;
    axim_rvalid = 0;

    // ---- reset state: handshakes forced low even with a legal request ----
    axis_awaddr = 32'h0012_3400; axis_awvalid = 1; axim_awready = 1;
    axis_araddr = 32'h0012_3400; axis_arvalid = 1; axim_arready = 1;
    #1;
    chk("rst_axim_awvalid", axim_awvalid, 0);
    chk("rst_axis_awready", axis_awready, 0);
    chk("rst_axim_arvalid", axim_arvalid, 0);
    chk("rst_axis_arready", axis_arready, 0);
    chk("rst_axis_bvalid", axis_bvalid, 0);
    chk("rst_axis_rvalid", axis_rvalid, 0);
    axis_awvalid = 0; axis_arvalid = 0;
    tick(); tick();
    rst_n = 1;
    tick();

    // ---- vector table: match / remap / permission, no handshake taken ----
    for (int k = 0; k < 11; k++) begin
      axim_awready = 0; axim_arready = 0;
      if (vt[k].wr) begin axis_awaddr = vt[k].addr; axis_awvalid = 1; end
      else          begin axis_araddr = vt[k].addr; axis_arvalid = 1; end
      #1;
      if (vt[k].wr) begin
        chk($sformatf("vec%0d_awvalid", k), axim_awvalid, vt[k].fwd);
        chk($sformatf("vec%0d_awready", k), axis_awready, !vt[k].fwd);
        if (vt[k].fwd) chk($sformatf("vec%0d_awaddr", k), axim_awaddr, vt[k].oaddr);
      end else begin
        chk($sformatf("vec%0d_arvalid", k), axim_arvalid, vt[k].fwd);
        chk($sformatf("vec%0d_arready", k), axis_arready, !vt[k].fwd);
        if (vt[k].fwd) chk($sformatf("vec%0d_araddr", k), axim_araddr, vt[k].oaddr);
      end
      axis_awvalid = 0; axis_arvalid = 0;
      tick();
    end

    // ---- forwarded write + read, zero-latency passthrough ----
    axis_awid = 4'd3; axis_awaddr = 32'h0012_3400; axis_awlen = 0; axis_awvalid = 1; axim_awready = 1;
    #1;
    chk("fw_awaddr", axim_awaddr, 32'h0212_3400);
    chk("fw_awid", axim_awid, 3);
    chk("fw_awready", axis_awready, 1);
    tick(); axis_awvalid = 0;
    axis_wdata = 64'hDEAD_BEEF_0123_4567; axis_wlast = 1; axis_wvalid = 1; axim_wready = 1;
    #1;
    chk("fw_wvalid", axim_wvalid, 1);
    chk("fw_wdata", axim_wdata, 64'hDEAD_BEEF_0123_4567);
    chk("fw_wready", axis_wready, 1);
    tick();
    chk("fw_w_closed", axim_wvalid, 0);
    axis_wvalid = 0;
    axim_bvalid = 1; axim_bid = 4'd3; axim_bresp = 2'b00; axis_bready = 1;
    #1;
    chk("fw_bvalid", axis_bvalid, 1);
    chk("fw_bid", axis_bid, 3);
    chk("fw_bresp", axis_bresp, 0);
    tick(); axim_bvalid = 0;
    axis_arid = 4'd3; axis_araddr = 32'h0012_3400; axis_arvalid = 1; axim_arready = 1;
    #1;
    chk("fr_araddr", axim_araddr, 32'h0212_3400);
    chk("fr_arready", axis_arready, 1);
    tick(); axis_arvalid = 0;
    axim_rvalid = 1; axim_rid = 4'd3; axim_rdata = 64'h1122_3344_5566_7788; axim_rlast = 1;
    axim_rresp = 2'b00; axis_rready = 1;
    #1;
    chk("fr_rvalid", axis_rvalid, 1);
    chk("fr_rdata", axis_rdata, 64'h1122_3344_5566_7788);
    chk("fr_rresp", axis_rresp, 0);
    tick(); axim_rvalid = 0; axim_rlast = 0;

    // ---- blocked write: 4 beats sunk, DECERR with captured id ----
    axis_awid = 4'd9; axis_awaddr = 32'h8000_0010; axis_awlen = 4'd3; axis_awvalid = 1;
    #1;
    chk("bw_awvalid_m", axim_awvalid, 0);
    chk("bw_awready", axis_awready, 1);
    tick(); axis_awvalid = 0; axim_wready = 0; axis_bready = 0;
    for (int b = 0; b < 4; b++) begin
      axis_wvalid = 1; axis_wlast = (b == 3);
      #1;
      chk($sformatf("bw_wready%0d", b), axis_wready, 1);
      chk($sformatf("bw_wvalid_m%0d", b), axim_wvalid, 0);
      chk($sformatf("bw_bvalid_early%0d", b), axis_bvalid, 0);
      tick();
    end
    axis_wvalid = 0; axis_wlast = 0;
    #1;
    chk("bw_bvalid", axis_bvalid, 1);
    chk("bw_bresp", axis_bresp, 2'b11);
    chk("bw_bid", axis_bid, 9);
    chk("bw_bready_m", axim_bready, 0);
    tick();
    chk("bw_bvalid_hold", axis_bvalid, 1);
    axis_bready = 1;
    tick();
    chk("bw_bvalid_done", axis_bvalid, 0);

    // ---- blocked read, arlen 7, rready toggling ----
    axis_arid = 4'd6; axis_araddr = 32'h4000_0000; axis_arlen = 4'd7; axis_arvalid = 1;
    #1;
    chk("br_arready", axis_arready, 1);
    chk("br_arvalid_m", axim_arvalid, 0);
    tick(); axis_arvalid = 0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      axis_rready = c[0];
      #1;
      chk("br_rvalid", axis_rvalid, 1);
      chk("br_rid", axis_rid, 6);
      chk("br_rresp", axis_rresp, 2'b11);
      chk("br_rdata", axis_rdata, 0);
      chk($sformatf("br_rlast_b%0d", beats), axis_rlast, beats == 7);
      if (axis_rready) beats++;
      tick();
    end
    chk("br_beats", beats, 8);
    chk("br_done", axis_rvalid, 0);
    axis_rready = 1;

    // ---- blocked AR waits for two forwarded reads to drain ----
    axim_arready = 1; axis_arlen = 0;
    for (int n = 1; n <= 2; n++) begin
      axis_arid = 4'(n); axis_araddr = 32'h0000_0100; axis_arvalid = 1;
      #1; chk($sformatf("dr_fwd%0d", n), axis_arready, 1);
      tick();
    end
    axis_arid = 4'd7; axis_araddr = 32'h4000_0000; axis_arvalid = 1;
    #1; chk("dr_stall0", axis_arready, 0);
    tick(); chk("dr_stall1", axis_arready, 0);
    axim_rvalid = 1; axim_rid = 4'd1; axim_rlast = 0; axim_rdata = 64'hAAAA;
    #1; chk("dr_pass_rid", axis_rid, 1); chk("dr_stall2", axis_arready, 0);
    tick(); axim_rlast = 1;
    #1; chk("dr_stall3", axis_arready, 0);
    tick(); axim_rid = 4'd2;
    #1; chk("dr_stall4", axis_arready, 0);
    tick(); axim_rvalid = 0; axim_rlast = 0;
    #1; chk("dr_accept", axis_arready, 1);
    tick(); axis_arvalid = 0;
    axim_rvalid = 1; axim_rid = 4'd2; axim_rdata = 64'hBBBB;  // must not leak through
    #1;
    chk("dr_err_rvalid", axis_rvalid, 1);
    chk("dr_err_rid", axis_rid, 7);
    chk("dr_err_rdata", axis_rdata, 0);
    chk("dr_err_rlast", axis_rlast, 1);
    chk("dr_err_rready_m", axim_rready, 0);
    tick(); axim_rvalid = 0;
    #1; chk("dr_err_done", axis_rvalid, 0);

    // ---- outstanding limit on writes (P_MAX_OUTST = 3) ----
    axim_awready = 1; axim_wready = 1; axis_awlen = 0; axis_awaddr = 32'h0000_1000;
    for (int n = 0; n < 3; n++) begin
      axis_awvalid = 1;
      #1; chk($sformatf("mx_aw%0d", n), axis_awready, 1);
      tick(); axis_awvalid = 0; axis_wvalid = 1; axis_wlast = 1;
      tick(); axis_wvalid = 0; axis_wlast = 0;
    end
    axis_awvalid = 1;
    #1; chk("mx_stall_rdy", axis_awready, 0); chk("mx_stall_vld", axim_awvalid, 0);
    tick(); chk("mx_stall_rdy2", axis_awready, 0);
    axim_bvalid = 1; axim_bresp = 0; axis_bready = 1;
    #1; chk("mx_same_cycle", axis_awready, 0);
    tick(); axim_bvalid = 0;
    #1; chk("mx_next_rdy", axis_awready, 1); chk("mx_next_vld", axim_awvalid, 1);
    tick(); axis_awvalid = 0; axis_wvalid = 1; axis_wlast = 1;
    tick(); axis_wvalid = 0; axis_wlast = 0;
    axim_bvalid = 1;
    tick(); tick(); tick();
    axim_bvalid = 0;

    // ---- reset during the 3rd beat of an error read ----
    axis_arid = 4'd4; axis_araddr = 32'h4000_0000; axis_arlen = 4'd7; axis_arvalid = 1;
    #1; chk("rr_accept", axis_arready, 1);
    tick(); axis_arvalid = 0;
    tick(); tick();
    chk("rr_beat3", axis_rvalid, 1);
    axis_araddr = 32'h0000_0200; axis_arvalid = 1;
    rst_n = 0;
    #1;
    chk("rr_rvalid", axis_rvalid, 0);
    chk("rr_arvalid_m", axim_arvalid, 0);
    chk("rr_arready", axis_arready, 0);
    tick(); rst_n = 1;
    #1;
    chk("rr_post_vld", axim_arvalid, 1);
    chk("rr_post_rdy", axis_arready, 1);
    chk("rr_post_addr", axim_araddr, 32'h0200_0200);
    tick(); axis_arvalid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
